// File: rtl/spi_pkg.sv
// Shared types and mode-decode constants for the
// SPI slave with TX/RX FIFOs.
package spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2
   } state_t;

   localparam logic CPOL_LOW  = 1'b0;
   localparam logic CPHA_LEAD = 1'b0;
   localparam logic ORDER_LSB = 1'b1;

endpackage

// File: rtl/spi_slave_fifo_if.sv
// Word-level TX/RX valid/ready bundle between
// the SPI slave and its local host.
interface spi_slave_fifo_if #(
   parameter int DATA_WIDTH = 8
);

   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_valid;
   logic                  rx_ready;

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready,
      output rx_data,
      output rx_valid,
      input  rx_ready
   );

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready,
      input  rx_data,
      input  rx_valid,
      output rx_ready
   );

endinterface

// File: rtl/spi_sync_fifo.sv
// Single-clock show-ahead FIFO with full/empty;
// head reads as zero while empty.
module spi_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [AW:0]      count;
   logic             do_wr;
   logic             do_rd;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign do_rd = rd_en && !empty;
   // a full FIFO still takes a write when it pops
   assign do_wr = wr_en && (!full || do_rd);
   assign rd_data = empty ? '0 : mem[rptr];

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_wr) begin
            wptr <= wptr + 1'b1;
         end
         if (do_rd) begin
            rptr <= rptr + 1'b1;
         end
         unique case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/spi_slave_fifo.sv
// SPI slave (all four modes, either bit order)
// oversampled on clk, with TX and RX word FIFOs.
module spi_slave_fifo #(
   parameter int DATA_WIDTH  = 8,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic cpol,
   input  logic cpha,
   input  logic lsb_first,
   spi_slave_fifo_if.slave bus,
   input  logic sclk,
   input  logic mosi,
   input  logic cs_n,
   output wire  miso,
   output logic busy,
   output logic tx_underrun,
   output logic rx_overflow,
   output logic frame_abort
);

   import spi_pkg::*;

   localparam int CW = $clog2(DATA_WIDTH + 1);

   typedef logic [DATA_WIDTH-1:0] word_t;

   logic [SYNC_STAGES-1:0] sclk_s;
   logic [SYNC_STAGES-1:0] mosi_s;
   logic [SYNC_STAGES-1:0] cs_s;
   logic                   sclk_d;
   logic                   cs_d;

   logic   sclk_q;
   logic   mosi_q;
   logic   cs_q;
   logic   sclk_rise;
   logic   sclk_fall;
   logic   cs_fall;
   logic   cs_rise;
   logic   lead;
   logic   trail;
   logic   sample;
   logic   change;

   logic   m_cpol;
   logic   m_cpha;
   logic   m_lsb;
   state_t state;
   state_t nstate;
   logic [CW-1:0] cnt;
   word_t  rx_sr;
   word_t  tx_sr;
   word_t  tx_head;
   logic   miso_q;
   logic   push_pend;

   logic   tx_full;
   logic   tx_empty;
   logic   rx_full;
   logic   rx_empty;
   logic   tx_push;
   logic   active;
   logic   last;
   logic   word_done;
   logic   start;
   logic   load;

   function automatic logic head_bit(word_t w, logic lsb);
      return (lsb == ORDER_LSB) ? w[0] : w[DATA_WIDTH-1];
   endfunction

   function automatic word_t advance(word_t w, logic lsb);
      return (lsb == ORDER_LSB) ? (w >> 1) : (w << 1);
   endfunction

   // sclk resets to its idle level so release makes no edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_s <= {SYNC_STAGES{cpol}};
         mosi_s <= '0;
         cs_s   <= '1;
         sclk_d <= cpol;
         cs_d   <= 1'b1;
      end else begin
         sclk_s <= {sclk_s[SYNC_STAGES-2:0], sclk};
         mosi_s <= {mosi_s[SYNC_STAGES-2:0], mosi};
         cs_s   <= {cs_s[SYNC_STAGES-2:0], cs_n};
         sclk_d <= sclk_s[SYNC_STAGES-1];
         cs_d   <= cs_s[SYNC_STAGES-1];
      end
   end

   assign sclk_q    = sclk_s[SYNC_STAGES-1];
   assign mosi_q    = mosi_s[SYNC_STAGES-1];
   assign cs_q      = cs_s[SYNC_STAGES-1];
   assign sclk_rise = sclk_q && !sclk_d;
   assign sclk_fall = !sclk_q && sclk_d;
   assign cs_fall   = !cs_q && cs_d;
   assign cs_rise   = cs_q && !cs_d;
   assign busy      = !cs_q;

   assign lead   = (m_cpol == CPOL_LOW) ? sclk_rise : sclk_fall;
   assign trail  = (m_cpol == CPOL_LOW) ? sclk_fall : sclk_rise;
   assign sample = (m_cpha == CPHA_LEAD) ? lead : trail;
   assign change = (m_cpha == CPHA_LEAD) ? trail : lead;

   assign active    = (state != ST_IDLE);
   assign last      = (cnt == CW'(DATA_WIDTH - 1));
   assign word_done = active && sample && last && !cs_rise;
   assign start     = !active && cs_fall;
   assign load      = start || word_done;

   always_comb begin
      nstate = state;
      unique case (state)
         ST_IDLE:  if (cs_fall) nstate = ST_LOAD;
         ST_LOAD:  nstate = word_done ? ST_LOAD : ST_SHIFT;
         ST_SHIFT: if (word_done) nstate = ST_LOAD;
         default:  nstate = ST_IDLE;
      endcase
      if (cs_rise) begin
         nstate = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         m_cpol      <= 1'b0;
         m_cpha      <= 1'b0;
         m_lsb       <= 1'b0;
         cnt         <= '0;
         rx_sr       <= '0;
         tx_sr       <= '0;
         miso_q      <= 1'b0;
         push_pend   <= 1'b0;
         tx_underrun <= 1'b0;
         rx_overflow <= 1'b0;
         frame_abort <= 1'b0;
      end else begin
         state       <= nstate;
         push_pend   <= word_done;
         tx_underrun <= load && tx_empty;
         rx_overflow <= push_pend && rx_full && !bus.rx_ready;
         frame_abort <= cs_rise && (cnt != '0);
         if (start) begin
            m_cpol <= cpol;
            m_cpha <= cpha;
            m_lsb  <= lsb_first;
         end
         if (cs_rise) begin
            cnt    <= '0;
            rx_sr  <= '0;
            tx_sr  <= '0;
            miso_q <= 1'b0;
         end else begin
            if (active && sample) begin
               cnt <= last ? '0 : cnt + 1'b1;
               if (m_lsb == ORDER_LSB) begin
                  rx_sr <= {mosi_q, rx_sr[DATA_WIDTH-1:1]};
               end else begin
                  rx_sr <= {rx_sr[DATA_WIDTH-2:0], mosi_q};
               end
            end
            // cpha=0 frame start puts the first bit out at once
            if (start && cpha == CPHA_LEAD) begin
               miso_q <= head_bit(tx_head, lsb_first);
               tx_sr  <= advance(tx_head, lsb_first);
            end else if (load) begin
               tx_sr <= tx_head;
            end else if (active && change) begin
               miso_q <= head_bit(tx_sr, m_lsb);
               tx_sr  <= advance(tx_sr, m_lsb);
            end
         end
      end
   end

   assign miso = cs_n ? 1'bz : miso_q;

   assign tx_push     = bus.tx_valid && bus.tx_ready;
   assign bus.tx_ready = !tx_full;

   spi_sync_fifo #(
      .WIDTH(DATA_WIDTH),
      .DEPTH(FIFO_DEPTH)
   ) u_tx_fifo (
      .clk(clk),
      .rst_n(rst_n),
      .wr_en(tx_push),
      .wr_data(bus.tx_data),
      .rd_en(load),
      .rd_data(tx_head),
      .full(tx_full),
      .empty(tx_empty)
   );

   assign bus.rx_valid = !rx_empty;

   spi_sync_fifo #(
      .WIDTH(DATA_WIDTH),
      .DEPTH(FIFO_DEPTH)
   ) u_rx_fifo (
      .clk(clk),
      .rst_n(rst_n),
      .wr_en(push_pend),
      .wr_data(rx_sr),
      .rd_en(bus.rx_ready),
      .rd_data(bus.rx_data),
      .full(rx_full),
      .empty(rx_empty)
   );

endmodule

// File: tb/tb_spi_slave_fifo.sv
// Directed bench: an SPI master model drives the
// slave pins while the host side loads and drains.
module tb_spi_slave_fifo;

   localparam int HALF = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cpol = 1'b0;
   logic cpha = 1'b0;
   logic lsb_first = 1'b0;
   logic sclk = 1'b0;
   logic mosi = 1'b0;
   logic cs_n = 1'b1;
   wire  miso;
   logic busy;
   logic tx_underrun;
   logic rx_overflow;
   logic frame_abort;

   int checks = 0;
   int errors = 0;
   int und_n = 0;
   int ovf_n = 0;
   int abt_n = 0;

   spi_slave_fifo_if #(.DATA_WIDTH(8)) bus ();

   spi_slave_fifo #(
      .DATA_WIDTH(8),
      .FIFO_DEPTH(4),
      .SYNC_STAGES(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .cpol(cpol),
      .cpha(cpha),
      .lsb_first(lsb_first),
      .bus(bus),
      .sclk(sclk),
      .mosi(mosi),
      .cs_n(cs_n),
      .miso(miso),
      .busy(busy),
      .tx_underrun(tx_underrun),
      .rx_overflow(rx_overflow),
      .frame_abort(frame_abort)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tx_underrun) und_n <= und_n + 1;
      if (rx_overflow) ovf_n <= ovf_n + 1;
      if (frame_abort) abt_n <= abt_n + 1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h",
                  tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_tx(input logic [7:0] w);
      int t;
      t = 0;
      while (!bus.tx_ready && t < 50) begin
         tick(1);
         t++;
      end
      chk("tx_ready", bus.tx_ready, 1);
      bus.tx_data  = w;
      bus.tx_valid = 1'b1;
      tick(1);
      bus.tx_valid = 1'b0;
   endtask

   task automatic pop_chk(input string tag,
                          input logic [7:0] exp);
      int t;
      t = 0;
      while (!bus.rx_valid && t < 50) begin
         tick(1);
         t++;
      end
      chk({tag, "_valid"}, bus.rx_valid, 1);
      chk(tag, bus.rx_data, exp);
      bus.rx_ready = 1'b1;
      tick(1);
      bus.rx_ready = 1'b0;
   endtask

   task automatic set_mode(input logic p,
                           input logic h,
                           input logic l);
      cpol = p;
      cpha = h;
      lsb_first = l;
      sclk = p;
      tick(4);
   endtask

   task automatic cs_low();
      cs_n = 1'b0;
      tick(HALF);
   endtask

   task automatic cs_high();
      tick(HALF);
      cs_n = 1'b1;
      tick(HALF);
   endtask

   task automatic xfer(input  logic [7:0] mo,
                       input  int nb,
                       output logic [7:0] mi);
      int b;
      mi = '0;
      for (int i = 0; i < nb; i++) begin
         b = lsb_first ? i : 7 - i;
         if (!cpha) begin
            mosi = mo[b];
            tick(HALF);
            sclk = ~cpol;
            mi[b] = miso;
            tick(HALF);
            sclk = cpol;
         end else begin
            sclk = ~cpol;
            mosi = mo[b];
            tick(HALF);
            sclk = cpol;
            mi[b] = miso;
            tick(HALF);
         end
      end
   endtask

   initial begin
      logic [7:0] mi;
      logic [7:0] acc;
      logic [7:0] sent;
      logic [1:0] md;
      int u0;
      int o0;
      int a0;
      bus.tx_data  = '0;
      bus.tx_valid = 1'b0;
      bus.rx_ready = 1'b0;

      tick(3);
      chk("rst_rx_valid", bus.rx_valid, 0);
      chk("rst_tx_ready", bus.tx_ready, 1);
      chk("rst_rx_data", bus.rx_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pulses",
          {tx_underrun, rx_overflow, frame_abort}, 0);
      rst_n = 1'b1;
      tick(4);

      for (int m = 0; m < 4; m++) begin
         md = 2'(m);
         set_mode(md[1], md[0], 1'b0);
         push_tx(8'h3C);
         cs_low();
         chk($sformatf("m%0d_busy", m), busy, 1);
         xfer(8'hA5, 8, mi);
         cs_high();
         chk($sformatf("m%0d_miso", m), mi, 8'h3C);
         pop_chk($sformatf("m%0d_rx", m), 8'hA5);
      end

      set_mode(1'b0, 1'b0, 1'b0);
      push_tx(8'hAA);
      push_tx(8'hBB);
      push_tx(8'hCC);
      cs_low();
      xfer(8'h11, 8, mi);
      chk("multi_miso0", mi, 8'hAA);
      xfer(8'h22, 8, mi);
      chk("multi_miso1", mi, 8'hBB);
      xfer(8'h33, 8, mi);
      chk("multi_miso2", mi, 8'hCC);
      cs_high();
      pop_chk("multi_rx0", 8'h11);
      pop_chk("multi_rx1", 8'h22);
      pop_chk("multi_rx2", 8'h33);

      set_mode(1'b0, 1'b0, 1'b1);
      push_tx(8'h3D);
      cs_low();
      chk("lsb_first_bit", miso, 1);
      xfer(8'h01, 8, mi);
      cs_high();
      chk("lsb_miso", mi, 8'h3D);
      pop_chk("lsb_rx", 8'h01);

      set_mode(1'b0, 1'b0, 1'b0);
      u0 = und_n;
      o0 = ovf_n;
      acc = '0;
      cs_low();
      for (int k = 1; k <= 5; k++) begin
         sent = 8'(k);
         xfer(sent, 8, mi);
         acc = acc | mi;
      end
      cs_high();
      chk("under_miso", acc, 0);
      chk("under_pulse", (und_n > u0) ? 1 : 0, 1);
      chk("ovf_once", ovf_n - o0, 1);
      pop_chk("ovf_rx0", 8'h01);
      pop_chk("ovf_rx1", 8'h02);
      pop_chk("ovf_rx2", 8'h03);
      pop_chk("ovf_rx3", 8'h04);
      chk("ovf_drained", bus.rx_valid, 0);

      a0 = abt_n;
      cs_low();
      xfer(8'hFF, 5, mi);
      cs_high();
      chk("abort_pulse", abt_n - a0, 1);
      chk("abort_nopush", bus.rx_valid, 0);
      push_tx(8'h96);
      cs_low();
      xfer(8'hC3, 8, mi);
      cs_high();
      chk("abort_next_miso", mi, 8'h96);
      pop_chk("abort_next_rx", 8'hC3);
      chk("abort_no_extra", abt_n - a0, 1);

      a0 = abt_n;
      push_tx(8'h77);
      push_tx(8'h88);
      cs_low();
      xfer(8'hF0, 4, mi);
      rst_n = 1'b0;
      tick(2);
      chk("mid_rx_valid", bus.rx_valid, 0);
      chk("mid_tx_ready", bus.tx_ready, 1);
      chk("mid_rx_data", bus.rx_data, 0);
      chk("mid_busy", busy, 0);
      chk("mid_miso", miso, 0);
      chk("mid_pulses",
          {tx_underrun, rx_overflow, frame_abort}, 0);
      cs_n = 1'b1;
      sclk = cpol;
      tick(2);
      rst_n = 1'b1;
      tick(4);
      chk("mid_no_abort", abt_n - a0, 0);
      push_tx(8'hE1);
      cs_low();
      xfer(8'h5A, 8, mi);
      cs_high();
      chk("post_rst_miso", mi, 8'hE1);
      pop_chk("post_rst_rx", 8'h5A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_slave_fifo.md
SPI_SLAVE_FIFO -- requirements
Module: spi_slave_fifo

Interface
REQ-001 Parameter DATA_WIDTH, 8, bits per SPI word; legal range 4..32.
REQ-002 Parameter FIFO_DEPTH, 4, entries in each of the TX and RX FIFOs; power of two, at least 2.
REQ-003 Parameter SYNC_STAGES, 2, flops in each pin synchronizer for sclk, mosi and cs_n; at least 2.
REQ-004 clk  in  1  system clock; the single clock domain; all ports are sampled on its rising edge.
REQ-005 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-006 cpol, cpha  in  1 each  SPI mode select.
REQ-007 lsb_first  in  1  bit order: 1 = LSB first, 0 = MSB first.
REQ-008 tx_data  in  DATA_WIDTH  word to transmit.
REQ-009 tx_valid  in  1  tx_data is valid.
REQ-010 tx_ready  out  1  TX FIFO not full.
REQ-011 rx_data  out  DATA_WIDTH  head of the RX FIFO (show-ahead).
REQ-012 rx_valid  out  1  RX FIFO not empty.
REQ-013 rx_ready  in  1  consumer accepts rx_data.
REQ-014 sclk, mosi, cs_n  in  1 each  SPI pins, asynchronous to clk.
REQ-015 miso  out  1  SPI data out; high-Z whenever the raw cs_n pin is high.
REQ-016 busy  out  1  synchronized cs_n is low.
REQ-017 tx_underrun, rx_overflow, frame_abort  out  1 each  one-clk event pulses.

Function
REQ-018 sclk, mosi and cs_n SHALL pass through SYNC_STAGES flops; edges are detected against one further registered copy of each.
REQ-019 cpol, cpha and lsb_first SHALL be latched on the synchronized cs_n falling edge and held until cs_n rises; changes while busy have no effect.
REQ-020 Sample edge = leading edge when cpha=0, trailing edge when cpha=1; change edge is the opposite edge; leading edge = rising if cpol=0, falling if cpol=1.
REQ-021 A frame is cs_n low; a frame SHALL carry any number of back-to-back words with no gap between them.
REQ-022 On each sample edge while busy: synchronized mosi shifts into the RX register (at the MSB end if lsb_first, else the LSB end) and the bit counter increments.
REQ-023 On the DATA_WIDTH-th sample edge of a word: counter wraps to 0; the assembled word SHALL be pushed to the RX FIFO on the next clk, visible at rx_data no later than SYNC_STAGES+3 clk after the completing sclk pin edge.
REQ-024 RX FIFO full at push time -> word dropped, existing contents kept, rx_overflow pulses.
REQ-025 RX pop occurs when rx_valid && rx_ready; a push and a pop in the same cycle are both honoured, including when the FIFO is full.
REQ-026 TX load: on cs_n fall, then on each word boundary, the TX FIFO head SHALL be popped into the shift register; an empty FIFO loads all-zeros and pulses tx_underrun.
REQ-027 cpha=0: first bit on miso within 1 clk of the cs_n fall; each following bit, including the first bit of the next word, changes on the change edge.
REQ-028 cpha=1: each bit, including the first, is driven on the change edge.
REQ-029 cs_n rise with bit counter != 0: partial word discarded, no push, frame_abort pulses; the counter and both shift registers clear in all cases.
REQ-030 TX push occurs when tx_valid && tx_ready; a push and a pop in the same cycle are both honoured.
REQ-031 Internal state SHALL be IDLE -> LOAD (1 clk) -> SHIFT; SHIFT -> LOAD on a word boundary; any state -> IDLE on cs_n rise.

Reset
REQ-032 While rst_n is low: FIFOs empty, rx_valid=0, tx_ready=1, rx_data=0, busy=0, all pulses 0, internal miso register 0, state IDLE.
REQ-033 Synchronizer flops SHALL reset: sclk to cpol, cs_n to 1, mosi to 0.
REQ-034 Reset asserted mid-frame SHALL abort the frame without a push or pulse; after release, the first complete frame operates normally.

Structure
REQ-035 Package spi_pkg SHALL hold the state enum typedef and the mode-decode constants.
REQ-036 Both FIFOs SHALL be instances of one sub-module, spi_sync_fifo (parameters WIDTH, DEPTH; show-ahead; full/empty flags).

Verification
REQ-037 All 4 modes, DATA_WIDTH=8: master sends 0xA5 while slave TX holds 0x3C -> rx_data=0xA5 and master receives 0x3C.
REQ-038 Frame of 3 words 0x11,0x22,0x33 with TX preloaded 0xAA,0xBB,0xCC -> RX FIFO holds 0x11,0x22,0x33 in order; master receives 0xAA,0xBB,0xCC.
REQ-039 lsb_first=1, master sends 0x01 LSB-first -> rx_data=0x01; first miso bit equals tx_data[0].
REQ-040 rx_ready=0, FIFO_DEPTH=4, 5 words sent -> first 4 retained, rx_overflow pulses once; empty TX FIFO -> miso 0 and tx_underrun pulses.
REQ-041 cs_n rises after 5 bits -> no push, frame_abort pulses; next full frame is received correctly.
REQ-042 rst_n asserted mid-word -> all outputs at reset values; a post-reset 0x5A frame is received correctly.
